// File: rtl/decrypt_pkg.sv
// Shared definitions for the decryption datapath.
//   - Channel select codes used by the demux and by mux_packer.
//   - Output holding register state encoding used by mux_packer.
package decrypt_pkg;

    localparam logic [1:0] CAESAR   = 2'd0;
    localparam logic [1:0] SCYTALE  = 2'd1;
    localparam logic [1:0] ZIGZAG   = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    // State of the one-entry output holding register.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/mux_packer.sv
// mux_packer: return path of the decryption datapath.
// Picks the byte stream of the selected decryption engine and packs consecutive
// bytes MSB-first into one MST_DWIDTH word, presented through a one-entry holding
// register with ready/valid backpressure.
//
// Ports
//   clk_sys              system clock, rising edge
//   rst_n                asynchronous active-low reset
//   select               0 caesar, 1 scytale, 2 zigzag, 3 none
//   data0_i / valid0_i   caesar byte stream
//   data1_i / valid1_i   scytale byte stream
//   data2_i / valid2_i   zigzag byte stream
//   ready_i              downstream takes data_o when valid_o && ready_i at an edge
//   data_o               packed word, first byte in the top SYS_DWIDTH bits
//   valid_o              data_o holds an unconsumed word
//   overflow_o           sticky: a completed word was dropped (register was full)
//
// Handshake: a word transfers on a rising edge where valid_o=1 and ready_i=1.
// While valid_o=1 and ready_i=0, data_o and valid_o hold. ready_i has no effect
// while valid_o=0.
module mux_packer
    import decrypt_pkg::*;
#(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic [1:0]            select,
    input  logic [SYS_DWIDTH-1:0] data0_i,
    input  logic                  valid0_i,
    input  logic [SYS_DWIDTH-1:0] data1_i,
    input  logic                  valid1_i,
    input  logic [SYS_DWIDTH-1:0] data2_i,
    input  logic                  valid2_i,
    input  logic                  ready_i,
    output logic [MST_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  overflow_o
);

    localparam int NBYTES = MST_DWIDTH / SYS_DWIDTH;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    logic [1:0]            sel_q;
    logic [CW-1:0]         count_q, count_d, base_count;
    logic [MST_DWIDTH-1:0] partial_q, partial_d, base_partial, word;
    logic [MST_DWIDTH-1:0] data_q;
    logic                  ovf_q;
    out_state_t            state_q, state_d;

    logic [SYS_DWIDTH-1:0] in_byte;
    logic                  in_valid;
    logic                  sel_change, last, complete, load, drop;

    // Input channel mux: only the selected engine can deliver a byte.
    always_comb begin
        in_byte  = '0;
        in_valid = 1'b0;
        case (select)
            CAESAR:  begin in_byte = data0_i; in_valid = valid0_i; end
            SCYTALE: begin in_byte = data1_i; in_valid = valid1_i; end
            ZIGZAG:  begin in_byte = data2_i; in_valid = valid2_i; end
            default: begin in_byte = '0;      in_valid = 1'b0;     end
        endcase
    end

    // Packer. A select change discards the partial word in the same cycle, so a
    // byte arriving with the new select lands in slot 0.
    always_comb begin
        sel_change   = (select != sel_q);
        base_count   = sel_change ? '0 : count_q;
        base_partial = sel_change ? '0 : partial_q;
        last         = (base_count == LAST_IDX);

        word = base_partial;
        for (int k = 0; k < NBYTES; k++) begin
            if (base_count == CW'(k)) begin
                word[MST_DWIDTH-1-k*SYS_DWIDTH -: SYS_DWIDTH] = in_byte;
            end
        end

        complete  = in_valid && last;
        count_d   = base_count;
        partial_d = base_partial;
        if (in_valid) begin
            count_d   = last ? '0 : base_count + CW'(1);
            partial_d = last ? '0 : word;
        end
    end

    // Output holding register FSM.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (ready_i) begin
                    // Consumed this edge; a word completing now refills it.
                    if (complete) begin
                        load = 1'b1;
                    end else begin
                        state_d = OUT_EMPTY;
                    end
                end else if (complete) begin
                    drop = 1'b1;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= SEL_NONE;
            count_q   <= '0;
            partial_q <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            state_q   <= OUT_EMPTY;
        end else begin
            sel_q     <= select;
            count_q   <= count_d;
            partial_q <= partial_d;
            state_q   <= state_d;
            if (load) begin
                data_q <= word;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign data_o     = data_q;
    assign valid_o    = (state_q == OUT_FULL);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_mux_packer.sv
// Bench for mux_packer: per-cycle vector table plus a scoreboard of words that
// must be handed over on the output handshake, and a hand-written reset sequence.
module tb_mux_packer;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [1:0]  select  = 2'd3;
    logic [7:0]  data0_i = '0, data1_i = '0, data2_i = '0;
    logic        valid0_i = 1'b0, valid1_i = 1'b0, valid2_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [31:0] data_o;
    logic        valid_o;
    logic        overflow_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  vm;
        logic [7:0]  d0, d1, d2;
        logic        rdy;
        logic        push;
        logic [31:0] word;
        logic        ev;
        logic [31:0] ed;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    mux_packer #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .select     (select),
        .data0_i    (data0_i),
        .valid0_i   (valid0_i),
        .data1_i    (data1_i),
        .valid1_i   (valid1_i),
        .data2_i    (data2_i),
        .valid2_i   (valid2_i),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sel, input logic [2:0] vm,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                input logic rdy, input logic push, input logic [31:0] word,
                                input logic ev, input logic [31:0] ed, input logic eo);
        vec_t v;
        v.sel = sel; v.vm = vm; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.rdy = rdy; v.push = push; v.word = word;
        v.ev = ev; v.ed = ed; v.eo = eo;
        return v;
    endfunction

    task automatic drive_idle();
        select = 2'd3;
        valid0_i = 1'b0; valid1_i = 1'b0; valid2_i = 1'b0;
        data0_i = '0; data1_i = '0; data2_i = '0;
        ready_i = 1'b0;
    endtask

    // Drive a row at the falling edge, then check outputs just after the next
    // rising edge. A handshake seen before the edge pops the scoreboard.
    task automatic apply_row(input vec_t v, input int idx);
        logic hs;
        logic [31:0] exp_w;
        @(negedge clk_sys);
        select   = v.sel;
        valid0_i = v.vm[0]; data0_i = v.d0;
        valid1_i = v.vm[1]; data1_i = v.d1;
        valid2_i = v.vm[2]; data2_i = v.d2;
        ready_i  = v.rdy;
        if (v.push) exp_q.push_back(v.word);
        #1;
        hs = valid_o && ready_i;
        exp_w = data_o;
        if (hs) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word row %0d: got %h expected none", idx, data_o);
            end else begin
                check($sformatf("handover row %0d", idx), exp_w, exp_q.pop_front());
            end
        end
        @(posedge clk_sys);
        #1;
        check($sformatf("valid row %0d", idx), {31'd0, valid_o}, {31'd0, v.ev});
        check($sformatf("overflow row %0d", idx), {31'd0, overflow_o}, {31'd0, v.eo});
        if (v.ev) check($sformatf("data row %0d", idx), data_o, v.ed);
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk_sys);
        drive_idle();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check({tag, " valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, " data"}, data_o, 32'd0);
        check({tag, " overflow"}, {31'd0, overflow_o}, 32'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: caesar AABBCCDD with ready high
        vecs.push_back(mk(0, 3'b001, 8'hAA, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'hBB, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'hCC, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'hDD, 0, 0, 1, 1, 32'hAABBCCDD, 1, 32'hAABBCCDD, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Test 2: scytale partial discarded by switch to zigzag
        vecs.push_back(mk(1, 3'b010, 0, 8'h11, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b011, 8'hEE, 8'h22, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 3'b100, 0, 0, 8'h33, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 3'b100, 0, 0, 8'h44, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 3'b100, 0, 0, 8'h55, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 3'b100, 0, 0, 8'h66, 1, 1, 32'h33445566, 1, 32'h33445566, 0));
        vecs.push_back(mk(2, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Test 4: ready arrives with the last byte of word 2, valid never drops
        vecs.push_back(mk(0, 3'b001, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'h04, 0, 0, 0, 1, 32'h01020304, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b001, 8'h05, 0, 0, 0, 0, 0, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b001, 8'h06, 0, 0, 0, 0, 0, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b001, 8'h07, 0, 0, 0, 0, 0, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b001, 8'h08, 0, 0, 1, 1, 32'h05060708, 1, 32'h05060708, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Test 5: select none and unselected channels are ignored
        vecs.push_back(mk(3, 3'b111, 8'h5A, 8'h5B, 8'h5C, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3, 3'b111, 8'h6A, 8'h6B, 8'h6C, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b101, 8'h5A, 0, 8'hA5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b101, 8'h7A, 0, 8'hA7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 8'h8A, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 8'h9A, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 8'hA1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 8'hA2, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, 8'hFF, 8'hA3, 8'hFF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 8'hA4, 0, 1, 1, 32'hA1A2A3A4, 1, 32'hA1A2A3A4, 0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Test 3: backpressure, second word dropped, overflow sticky
        vecs.push_back(mk(0, 3'b001, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 8'h04, 0, 0, 0, 1, 32'h01020304, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b001, 8'h05, 0, 0, 0, 0, 0, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b001, 8'h06, 0, 0, 0, 0, 0, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b001, 8'h07, 0, 0, 0, 0, 0, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b001, 8'h08, 0, 0, 0, 0, 0, 1, 32'h01020304, 1));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        // Test 6 head: two bytes of a word that reset will discard
        vecs.push_back(mk(0, 3'b001, 8'hC1, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'b001, 8'hC2, 0, 0, 1, 0, 0, 0, 0, 1));

        // Reset state
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset valid", {31'd0, valid_o}, 32'd0);
        check("reset data", data_o, 32'd0);
        check("reset overflow", {31'd0, overflow_o}, 32'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_row(vecs[i], i);
        end

        // Test 6: reset mid-word, then a fresh word held with valid_o=1, reset again
        async_reset_check("reset mid-word");
        apply_row(mk(0, 3'b001, 8'hD1, 0, 0, 0, 0, 0, 0, 0, 0), 100);
        apply_row(mk(0, 3'b001, 8'hD2, 0, 0, 0, 0, 0, 0, 0, 0), 101);
        apply_row(mk(0, 3'b001, 8'hD3, 0, 0, 0, 0, 0, 0, 0, 0), 102);
        apply_row(mk(0, 3'b001, 8'hD4, 0, 0, 0, 1, 32'hD1D2D3D4, 1, 32'hD1D2D3D4, 0), 103);
        async_reset_check("reset with valid");
        apply_row(mk(0, 3'b001, 8'hE1, 0, 0, 1, 0, 0, 0, 0, 0), 104);
        apply_row(mk(0, 3'b001, 8'hE2, 0, 0, 1, 0, 0, 0, 0, 0), 105);
        apply_row(mk(0, 3'b001, 8'hE3, 0, 0, 1, 0, 0, 0, 0, 0), 106);
        apply_row(mk(0, 3'b001, 8'hE4, 0, 0, 1, 1, 32'hE1E2E3E4, 1, 32'hE1E2E3E4, 0), 107);
        apply_row(mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0), 108);

        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
